// File: rtl/mem_cmd_sequencer.sv
// mem_cmd_sequencer: turns upstream switch/key I/O requests into req/ack
// memory accesses: a single-word write, a single-word read, or a zero-fill
// sweep over word addresses 0..CLEAR_WORDS-1, with a per-word ack timeout.
//
// Handshakes:
//   Upstream: memDone=1 means the block is idle, and a rising edge on ioDone
//   is accepted. The command inputs are captured in that same cycle. Edges
//   that arrive while memDone=0 are dropped.
//   Memory: mem_req rises together with valid mem_we/mem_addr/mem_wdata. All
//   four hold until a cycle in which mem_ack is sampled high. That cycle
//   transfers exactly one word, and mem_rdata is valid in it for reads.
//   mem_ack is ignored while mem_req is low.
module mem_cmd_sequencer #(
    parameter int ADDR_W      = 25,
    parameter int DATA_W      = 16,
    parameter int CLEAR_WORDS = 1024,
    parameter int TIMEOUT     = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ioDone,
    input  logic [1:0]        modeOutput,
    input  logic [ADDR_W-1:0] memoryAddress,
    input  logic [DATA_W-1:0] ioDataOut,
    output logic              memDone,
    output logic [DATA_W-1:0] rdData,
    output logic              rdValid,
    output logic              err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic [1:0]        dbg_state
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_CLEAR  = 2'd2;

    // Final word of the clear sweep and final wait cycle before abort.
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(CLEAR_WORDS - 1);
    localparam logic [15:0]       TMO_LAST  = 16'(TIMEOUT - 1);

    logic [1:0]        state_q,     state_d;
    logic              req_q,       req_d;
    logic              mem_req_q,   mem_req_d;
    logic              mem_we_q,    mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] rd_data_q,   rd_data_d;
    logic              rd_valid_q,  rd_valid_d;
    logic              err_q,       err_d;
    logic [15:0]       tmo_q,       tmo_d;

    logic new_req;
    logic tmo_hit;

    assign new_req = ioDone & ~req_q;
    assign tmo_hit = (tmo_q == TMO_LAST);

    // Next-state logic for the command FSM, memory port, and timeout counter.
    always_comb begin
        state_d     = state_q;
        req_d       = ioDone;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rd_data_d   = rd_data_q;
        rd_valid_d  = 1'b0;
        err_d       = err_q;
        tmo_d       = tmo_q;

        case (state_q)
            S_IDLE: begin
                if (new_req) begin
                    err_d     = 1'b0;
                    mem_req_d = 1'b1;
                    tmo_d     = '0;
                    if (modeOutput == 2'b00) begin
                        state_d     = S_CLEAR;
                        mem_we_d    = 1'b1;
                        mem_addr_d  = '0;
                        mem_wdata_d = '0;
                    end else begin
                        state_d     = S_ACCESS;
                        mem_we_d    = modeOutput[1];
                        mem_addr_d  = memoryAddress;
                        mem_wdata_d = ioDataOut;
                    end
                end
            end

            S_ACCESS: begin
                // A late ack takes priority over a timeout in the same cycle.
                if (mem_ack) begin
                    mem_req_d = 1'b0;
                    tmo_d     = '0;
                    state_d   = S_IDLE;
                    if (!mem_we_q) begin
                        rd_data_d  = mem_rdata;
                        rd_valid_d = 1'b1;
                    end
                end else if (tmo_hit) begin
                    mem_req_d = 1'b0;
                    err_d     = 1'b1;
                    state_d   = S_IDLE;
                end else begin
                    tmo_d = tmo_q + 16'd1;
                end
            end

            S_CLEAR: begin
                if (mem_ack) begin
                    tmo_d = '0;
                    if (mem_addr_q == LAST_ADDR) begin
                        mem_req_d = 1'b0;
                        state_d   = S_IDLE;
                    end else begin
                        mem_addr_d = mem_addr_q + ADDR_W'(1);
                    end
                end else if (tmo_hit) begin
                    mem_req_d = 1'b0;
                    err_d     = 1'b1;
                    state_d   = S_IDLE;
                end else begin
                    tmo_d = tmo_q + 16'd1;
                end
            end

            default: begin
                state_d   = S_IDLE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    // State registers with synchronous reset. req_q resets high so that a
    // level held through reset is not treated as a fresh request.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            req_q       <= 1'b1;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rd_data_q   <= '0;
            rd_valid_q  <= 1'b0;
            err_q       <= 1'b0;
            tmo_q       <= '0;
        end else begin
            state_q     <= state_d;
            req_q       <= req_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rd_data_q   <= rd_data_d;
            rd_valid_q  <= rd_valid_d;
            err_q       <= err_d;
            tmo_q       <= tmo_d;
        end
    end

    assign memDone   = (state_q == S_IDLE);
    assign rdData    = rd_data_q;
    assign rdValid   = rd_valid_q;
    assign err       = err_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_cmd_sequencer.sv
// Testbench for mem_cmd_sequencer: directed scenarios followed by random
// commands, checked against a command-level model (expected word list,
// busy-cycle count, read value, error flag) and a behavioural memory.
module tb_mem_cmd_sequencer;

    localparam int ADDR_W      = 25;
    localparam int DATA_W      = 16;
    localparam int CLEAR_WORDS = 4;
    localparam int TIMEOUT     = 8;
    localparam int ACC_W       = 1 + ADDR_W + DATA_W;
    localparam int BUSY_LIMIT  = 200;

    // ---------------- clock / reset / DUT ----------------
    logic              clk = 1'b0;
    logic              reset;
    logic              ioDone;
    logic [1:0]        modeOutput;
    logic [ADDR_W-1:0] memoryAddress;
    logic [DATA_W-1:0] ioDataOut;
    logic              memDone;
    logic [DATA_W-1:0] rdData;
    logic              rdValid;
    logic              err;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata = '0;
    logic              mem_ack = 1'b0;
    logic [1:0]        dbg_state;

    always #5 clk = ~clk;

    mem_cmd_sequencer #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W),
        .CLEAR_WORDS(CLEAR_WORDS), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .reset(reset), .ioDone(ioDone), .modeOutput(modeOutput),
        .memoryAddress(memoryAddress), .ioDataOut(ioDataOut),
        .memDone(memDone), .rdData(rdData), .rdValid(rdValid), .err(err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .dbg_state(dbg_state)
    );

    // ---------------- scoreboard state ----------------
    int test_cnt = 0;
    int fail_cnt = 0;
    logic [ACC_W-1:0]  exp_q[$];
    logic [ACC_W-1:0]  act_q[$];
    logic [DATA_W-1:0] mem_model [logic [ADDR_W-1:0]];
    int                ack_wait = 0;   // wait cycles before ack; -1 = never
    bit                stray_en = 0;   // random acks while mem_req is low
    logic [DATA_W-1:0] rd_exp = '0;
    logic              err_exp = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        test_cnt++;
        assert (obs === exp) else begin
            fail_cnt++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [ACC_W-1:0] pack(input logic we, input logic [ADDR_W-1:0] a,
                                             input logic [DATA_W-1:0] d);
        return {we, a, (we ? d : {DATA_W{1'b0}})};
    endfunction

    // ---------------- memory responder / bus monitor ----------------
    logic [ACC_W-1:0] word_snap = '0;
    int               word_cyc  = 0;

    always @(negedge clk) begin
        if (mem_req === 1'b1) begin
            if (word_cyc > 0)
                chk("bus_stable", pack(mem_we, mem_addr, mem_wdata), word_snap);
            else
                word_snap = pack(mem_we, mem_addr, mem_wdata);
            if (ack_wait >= 0 && word_cyc == ack_wait) begin
                mem_ack = 1'b1;
                if (mem_we) begin
                    mem_model[mem_addr] = mem_wdata;
                end else begin
                    if (!mem_model.exists(mem_addr))
                        mem_model[mem_addr] = DATA_W'($urandom);
                    mem_rdata = mem_model[mem_addr];
                end
                act_q.push_back(pack(mem_we, mem_addr, mem_wdata));
                word_cyc = 0;
            end else begin
                mem_ack   = 1'b0;
                mem_rdata = DATA_W'($urandom);
                word_cyc++;
            end
        end else begin
            word_cyc  = 0;
            mem_ack   = stray_en ? 1'($urandom_range(0, 1)) : 1'b0;
            mem_rdata = DATA_W'($urandom);
        end
    end

    // ---------------- driver: one command, end to end ----------------
    task automatic run_cmd(input logic [1:0] mode, input logic [ADDR_W-1:0] addr,
                           input logic [DATA_W-1:0] data, input int wait_c,
                           input bit hold, input bit repulse);
        int   words;
        int   busy_exp;
        int   busy;
        int   rdv_cnt;
        bit   tmo;
        bit   done;
        bit   rep;
        logic [DATA_W-1:0] rd_seen;
        tmo      = (wait_c < 0) || (wait_c > TIMEOUT - 1);
        words    = (mode == 2'b00) ? CLEAR_WORDS : 1;
        busy_exp = tmo ? TIMEOUT : words * (wait_c + 1);
        rep      = repulse && (busy_exp >= 3);
        busy     = 0;
        rdv_cnt  = 0;
        done     = 0;
        rd_seen  = '0;
        ack_wait = wait_c;
        exp_q.delete();
        act_q.delete();
        if (!tmo) begin
            if (mode == 2'b00)
                for (int i = 0; i < CLEAR_WORDS; i++) exp_q.push_back(pack(1'b1, ADDR_W'(i), '0));
            else
                exp_q.push_back(pack(mode[1], addr, data));
        end

        modeOutput    = mode;
        memoryAddress = addr;
        ioDataOut     = data;
        ioDone        = 1'b1;
        for (int k = 1; k <= BUSY_LIMIT && !done; k++) begin
            @(negedge clk);
            if (k == 1) chk("err_clear_on_accept", err, 1'b0);
            if (rdValid === 1'b1) begin
                rdv_cnt++;
                rd_seen = rdData;
                chk("memdone_with_rdvalid", memDone, 1'b1);
            end
            if (memDone === 1'b1) done = 1;
            else                  busy++;
            modeOutput    = 2'($urandom);
            memoryAddress = ADDR_W'($urandom);
            ioDataOut     = DATA_W'($urandom);
            if (!hold) ioDone = rep && (k == 2);
        end
        chk("cmd_completes", done, 1'b1);
        chk("busy_cycles", busy, busy_exp);

        err_exp = tmo;
        if (mode == 2'b01 && !tmo) rd_exp = mem_model[addr];
        chk("err", err, err_exp);
        chk("rd_valid_count", rdv_cnt, (mode == 2'b01 && !tmo) ? 1 : 0);
        if (rdv_cnt > 0) chk("rd_data_at_valid", rd_seen, rd_exp);
        chk("rd_data", rdData, rd_exp);
        chk("mem_req_low_after", mem_req, 1'b0);

        if (hold) begin
            repeat (3) begin
                @(negedge clk);
                chk("held_no_retrigger_req", mem_req, 1'b0);
                chk("held_no_retrigger_done", memDone, 1'b1);
                chk("held_no_rdvalid", rdValid, 1'b0);
            end
        end
        ioDone = 1'b0;
        @(negedge clk);
        chk("rdvalid_one_cycle", rdValid, 1'b0);
        chk("acc_count", act_q.size(), exp_q.size());
        for (int i = 0; i < act_q.size() && i < exp_q.size(); i++)
            chk("acc_word", act_q[i], exp_q[i]);
        act_q.delete();
        exp_q.delete();
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not reach the end, failed=%0d", fail_cnt);
        $fatal(1, "watchdog expired");
    end

    // ---------------- directed + random stimulus ----------------
    initial begin
        logic [1:0]        m;
        logic [ADDR_W-1:0] a;
        int                w;
        int                r;

        reset = 1'b1; ioDone = 1'b0; modeOutput = '0; memoryAddress = '0; ioDataOut = '0;
        repeat (3) @(negedge clk);
        chk("rst_memDone", memDone, 1'b1);
        chk("rst_rdData", rdData, '0);
        chk("rst_rdValid", rdValid, 1'b0);
        chk("rst_err", err, 1'b0);
        chk("rst_mem_req", mem_req, 1'b0);
        chk("rst_mem_we", mem_we, 1'b0);
        chk("rst_mem_addr", mem_addr, '0);
        chk("rst_mem_wdata", mem_wdata, '0);
        reset = 1'b0;
        @(negedge clk);

        // Write with four wait cycles, then read it back with a zero-wait ack.
        run_cmd(2'b10, 25'h1ABCD, 16'hBEEF, 4, 0, 0);
        run_cmd(2'b01, 25'h1ABCD, 16'h0000, 0, 0, 0);
        chk("readback_beef", rdData, 16'hBEEF);

        // Clear sweep, zero-wait and with waits.
        run_cmd(2'b00, 25'h155, 16'h7777, 0, 0, 0);
        run_cmd(2'b00, 25'h0, 16'h0, 2, 0, 0);
        run_cmd(2'b01, 25'h3, 16'h0, 1, 0, 0);
        chk("cleared_word", rdData, 16'h0000);

        // Re-fill a nonzero read value, then time out a read.
        run_cmd(2'b11, 25'h1ABCD, 16'hBEEF, 0, 0, 0);
        run_cmd(2'b01, 25'h1ABCD, 16'h0, 0, 0, 0);
        run_cmd(2'b01, 25'h1ABCD, 16'h0, -1, 0, 0);
        chk("timeout_err", err, 1'b1);
        chk("timeout_rd_unchanged", rdData, 16'hBEEF);
        run_cmd(2'b11, 25'h2, 16'h1234, 1, 0, 0);
        // Ack exactly in the final allowed cycle wins; one cycle later aborts.
        run_cmd(2'b10, 25'h5, 16'hA5A5, TIMEOUT - 1, 0, 0);
        run_cmd(2'b01, 25'h5, 16'h0, TIMEOUT, 0, 0);
        run_cmd(2'b00, 25'h0, 16'h0, -1, 0, 0);
        run_cmd(2'b01, 25'h5, 16'h0, 3, 0, 0);
        chk("after_abort_read", rdData, 16'hA5A5);

        // Second pulse mid-read is dropped; level held across completion is inert.
        run_cmd(2'b01, 25'h1ABCD, 16'h0, 4, 0, 1);
        run_cmd(2'b10, 25'h7, 16'h4321, 2, 1, 0);

        // Level held high through reset issues nothing afterwards.
        ioDone = 1'b1; reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        rd_exp = '0; err_exp = 1'b0;
        repeat (4) begin
            @(negedge clk);
            chk("held_reset_no_req", mem_req, 1'b0);
            chk("held_reset_done", memDone, 1'b1);
        end
        chk("held_reset_rdData", rdData, rd_exp);
        ioDone = 1'b0;
        @(negedge clk);

        // Reset during the second cycle of a clear abandons it.
        run_cmd(2'b01, 25'h7, 16'h0, 0, 0, 0);
        ack_wait = 0; modeOutput = 2'b00; ioDone = 1'b1;
        @(negedge clk);
        ioDone = 1'b0;
        chk("clear_started", mem_req, 1'b1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("rst_mid_mem_req", mem_req, 1'b0);
        chk("rst_mid_mem_addr", mem_addr, '0);
        chk("rst_mid_memDone", memDone, 1'b1);
        chk("rst_mid_err", err, 1'b0);
        chk("rst_mid_rdData", rdData, '0);
        chk("rst_mid_mem_we", mem_we, 1'b0);
        repeat (5) begin
            @(negedge clk);
            chk("rst_mid_no_req", mem_req, 1'b0);
        end
        act_q.delete();
        rd_exp = '0; err_exp = 1'b0;

        // Random commands with stray acks while idle.
        stray_en = 1;
        for (int i = 0; i < 40; i++) begin
            m = 2'($urandom_range(0, 3));
            r = $urandom_range(0, 9);
            w = (r == 0) ? -1 : ((r == 1) ? TIMEOUT - 1 : $urandom_range(0, 3));
            a = ($urandom_range(0, 1) == 1) ? ADDR_W'($urandom_range(0, 5)) : ADDR_W'($urandom);
            run_cmd(m, a, DATA_W'($urandom), w, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
        end
        stray_en = 0;

        $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
        $finish;
    end

endmodule
